// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//
// Decode / operand-fetch stage of the RISC-16 pipeline. It sits between fetch
// and execute and is the only reader of the general-purpose register file.
// Each cycle it decodes one instruction, reads up to two source registers
// (with a bypass from the writeback port), and checks a per-register pending
// scoreboard so that RAW and WAW hazards stall. Decoded operands are held in a
// single-entry valid/ready output register.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  fetch handshake; in_instr and in_pc are the payload
//   rf_addr_1/2          register-file read addresses (combinational)
//   rf_data_1/2          register-file read data (combinational)
//   wb_en/dest/data      writeback port, the same signals that write the RF
//   flush                squash the held output entry
//   out_valid/out_ready  execute handshake
//   out_op, out_pc       opcode and instruction address
//   out_a, out_b         source operands (0 when the opcode has no such source)
//   out_imm              expanded immediate
//   out_dest, out_wr     destination register and its write enable
// -----------------------------------------------------------------------------
module operand_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    output logic [2:0]  rf_addr_1,
    output logic [2:0]  rf_addr_2,
    input  logic [15:0] rf_data_1,
    input  logic [15:0] rf_data_2,
    input  logic        wb_en,
    input  logic [2:0]  wb_dest,
    input  logic [15:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_op,
    output logic [15:0] out_pc,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_imm,
    output logic [2:0]  out_dest,
    output logic        out_wr
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_NAND = 3'd2,
        OP_LUI  = 3'd3,
        OP_SW   = 3'd4,
        OP_LW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_JALR = 3'd7
    } opcode_t;

    opcode_t     op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rc;

    logic        use_1;
    logic        use_2;
    logic        wr;
    logic [15:0] imm;
    logic [15:0] operand_1;
    logic [15:0] operand_2;

    // Bit 0 of the scoreboard is kept as a constant-zero bit so that every
    // register index can address it directly; it is never set.
    logic [7:0]  pending;
    logic [7:0]  pending_next;
    logic [7:0]  eff_pending;
    logic        hazard;
    logic        issue;

    assign op = opcode_t'(in_instr[15:13]);
    assign ra = in_instr[12:10];
    assign rb = in_instr[9:7];
    assign rc = in_instr[2:0];

    // Register-file read addresses come straight from the instruction bits so
    // the RF read starts as early as possible in the cycle.
    assign rf_addr_1 = rb;
    assign rf_addr_2 = (op == OP_SW || op == OP_BEQ) ? ra : rc;

    // Opcode decode: which sources are used, whether a register is written,
    // and how the immediate is expanded.
    always_comb begin
        use_1 = (op != OP_LUI);
        use_2 = 1'b0;
        wr    = 1'b0;
        imm   = 16'h0000;

        case (op)
            OP_ADD, OP_NAND, OP_SW, OP_BEQ: use_2 = 1'b1;
            default:                        use_2 = 1'b0;
        endcase

        case (op)
            OP_ADD, OP_ADDI, OP_NAND, OP_LUI, OP_LW, OP_JALR: wr = (ra != 3'd0);
            default:                                          wr = 1'b0;
        endcase

        case (op)
            OP_ADDI, OP_SW, OP_LW, OP_BEQ: imm = {{9{in_instr[6]}}, in_instr[6:0]};
            OP_LUI:                        imm = {in_instr[9:0], 6'b000000};
            default:                       imm = 16'h0000;
        endcase
    end

    // Operand selection: r0 is hard-wired to zero, a same-cycle writeback to
    // the source register is forwarded, and unused sources are zeroed so the
    // execute stage never sees stale register contents.
    always_comb begin
        operand_1 = 16'h0000;
        operand_2 = 16'h0000;

        if (use_1 && rb != 3'd0) begin
            operand_1 = (wb_en && wb_dest == rb) ? wb_data : rf_data_1;
        end
        if (use_2 && rf_addr_2 != 3'd0) begin
            operand_2 = (wb_en && wb_dest == rf_addr_2) ? wb_data : rf_data_2;
        end
    end

    // A writeback landing this cycle retires its pending bit immediately, so
    // an instruction waiting on it can issue in the same cycle.
    always_comb begin
        eff_pending = pending;
        if (wb_en) begin
            eff_pending[wb_dest] = 1'b0;
        end
        eff_pending[0] = 1'b0;
    end

    assign hazard = (use_1 && eff_pending[rb])        ||
                    (use_2 && eff_pending[rf_addr_2]) ||
                    (wr    && eff_pending[ra]);

    // in_ready deliberately ignores in_valid so fetch can look at it freely.
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign issue    = in_valid && in_ready;

    // Scoreboard next state. Clears are applied first and the issue set last,
    // so a set always wins over a clear on the same bit. A flushed entry that
    // execute never took will never write back, hence its bit is released.
    always_comb begin
        pending_next = pending;
        if (wb_en) begin
            pending_next[wb_dest] = 1'b0;
        end
        if (flush && out_valid && out_wr && !out_ready) begin
            pending_next[out_dest] = 1'b0;
        end
        if (issue && wr) begin
            pending_next[ra] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 8'h00;
        end else begin
            pending <= pending_next;
        end
    end

    // Single-entry output register. It loads on issue, empties when execute
    // consumes it or when it is flushed, and otherwise holds its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op    <= 3'd0;
            out_pc    <= 16'h0000;
            out_a     <= 16'h0000;
            out_b     <= 16'h0000;
            out_imm   <= 16'h0000;
            out_dest  <= 3'd0;
            out_wr    <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_op    <= in_instr[15:13];
            out_pc    <= in_pc;
            out_a     <= operand_1;
            out_b     <= operand_2;
            out_imm   <= imm;
            out_dest  <= ra;
            out_wr    <= wr;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
//
// Self-checking bench for operand_fetch. A directed table walks through the
// hazard, bypass, stall and flush cases with hand-computed expectations, a
// short hand-written sequence covers reset asserted during a stall, and a
// randomized phase checks every cycle against a behavioural model built from
// per-opcode attribute tables, a pending-register set and a held entry.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic [2:0]  rf_addr_1;
    logic [2:0]  rf_addr_2;
    logic [15:0] rf_data_1;
    logic [15:0] rf_data_2;
    logic        wb_en;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [15:0] out_pc;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_imm;
    logic [2:0]  out_dest;
    logic        out_wr;

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .rf_addr_1 (rf_addr_1),
        .rf_addr_2 (rf_addr_2),
        .rf_data_1 (rf_data_1),
        .rf_data_2 (rf_data_2),
        .wb_en     (wb_en),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_pc    (out_pc),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_imm   (out_imm),
        .out_dest  (out_dest),
        .out_wr    (out_wr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file environment: ri starts at i*0x1111, r0 holds junk so the
    // stage's own zeroing of r0 is exercised.
    logic [15:0] rf [8];
    assign rf_data_1 = rf[rf_addr_1];
    assign rf_data_2 = rf[rf_addr_2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'(i * 32'h1111);
            rf[0] <= 16'hDEAD;
        end else if (wb_en && wb_dest != 3'd0) begin
            rf[wb_dest] <= wb_data;
        end
    end

    typedef struct packed {
        logic        in_valid;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        out_ready;
        logic        flush;
        logic        wb_en;
        logic [2:0]  wb_dest;
        logic [15:0] wb_data;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        in_ready;
        logic [2:0]  rf_addr_2;
        logic        out_valid;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [2:0]  dest;
        logic        wr;
    } vec_t;

    // Per-opcode attribute tables, bit i describes opcode i.
    localparam logic [7:0] HAS_SRC1    = 8'hF7;  // everything but lui
    localparam logic [7:0] SRC2_IS_RC  = 8'h05;  // add, nand
    localparam logic [7:0] SRC2_IS_RA  = 8'h50;  // sw, beq
    localparam logic [7:0] WRITES_RA   = 8'hAF;  // add, addi, nand, lui, lw, jalr
    localparam logic [7:0] IMM7_SIGNED = 8'h72;  // addi, sw, lw, beq

    int compared;
    int mismatched;

    // Model state: set of pending registers and the entry held for execute.
    logic [7:0]  m_pend;
    logic        m_valid;
    logic [2:0]  m_op;
    logic [15:0] m_pc;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [15:0] m_imm;
    logic [2:0]  m_dest;
    logic        m_wr;

    logic        samp_in_ready;
    logic [2:0]  samp_rf_addr_2;

    vec_t vecs [16];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        in_valid  = s.in_valid;
        in_instr  = s.instr;
        in_pc     = s.pc;
        out_ready = s.out_ready;
        flush     = s.flush;
        wb_en     = s.wb_en;
        wb_dest   = s.wb_dest;
        wb_data   = s.wb_data;
    endtask

    task automatic modelReset();
        m_pend  = 8'h00;
        m_valid = 1'b0;
        m_op    = 3'd0;
        m_pc    = 16'h0000;
        m_a     = 16'h0000;
        m_b     = 16'h0000;
        m_imm   = 16'h0000;
        m_dest  = 3'd0;
        m_wr    = 1'b0;
    endtask

    function automatic logic [15:0] regValue(input logic [2:0] r, input stim_t s);
        if (r == 3'd0) return 16'h0000;
        if (s.wb_en && s.wb_dest == r) return s.wb_data;
        return rf[r];
    endfunction

    // One clock cycle: drive at posedge+1, check combinational outputs
    // mid-cycle, advance the model across the edge, check registered outputs
    // at the following posedge+1.
    task automatic runCycle(input stim_t s);
        logic [2:0]  op, ra, rb, rc, src2;
        logic        use1, use2, wr, hz, rdy, issue;
        logic [15:0] va, vb, imm;
        logic [7:0]  live, np;

        applyStimulus(s);
        #3;
        op   = s.instr[15:13];
        ra   = s.instr[12:10];
        rb   = s.instr[9:7];
        rc   = s.instr[2:0];
        use1 = HAS_SRC1[op];
        use2 = SRC2_IS_RC[op] || SRC2_IS_RA[op];
        src2 = SRC2_IS_RA[op] ? ra : rc;
        wr   = WRITES_RA[op] && (ra != 3'd0);

        live = m_pend;
        if (s.wb_en) live[s.wb_dest] = 1'b0;
        live[0] = 1'b0;
        hz  = (use1 && live[rb]) || (use2 && live[src2]) || (wr && live[ra]);
        rdy = (!m_valid || s.out_ready) && !hz && !s.flush;

        va  = use1 ? regValue(rb, s) : 16'h0000;
        vb  = use2 ? regValue(src2, s) : 16'h0000;
        if (IMM7_SIGNED[op])     imm = {{9{s.instr[6]}}, s.instr[6:0]};
        else if (op == 3'd3)     imm = {s.instr[9:0], 6'b000000};
        else                     imm = 16'h0000;

        samp_in_ready  = in_ready;
        samp_rf_addr_2 = rf_addr_2;
        checkOutput("in_ready", 16'(in_ready), 16'(rdy));
        checkOutput("rf_addr_1", 16'(rf_addr_1), 16'(rb));
        checkOutput("rf_addr_2", 16'(rf_addr_2), 16'(src2));

        issue = s.in_valid && rdy;
        np = m_pend;
        if (s.wb_en) np[s.wb_dest] = 1'b0;
        if (s.flush && m_valid && m_wr && !s.out_ready) np[m_dest] = 1'b0;
        if (issue && wr) np[ra] = 1'b1;

        @(posedge clk);
        m_pend = np;
        if (issue) begin
            m_valid = 1'b1;
            m_op    = op;
            m_pc    = s.pc;
            m_a     = va;
            m_b     = vb;
            m_imm   = imm;
            m_dest  = ra;
            m_wr    = wr;
        end else if (s.flush || s.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        checkOutput("out_valid", 16'(out_valid), 16'(m_valid));
        checkOutput("out_op", 16'(out_op), 16'(m_op));
        checkOutput("out_pc", out_pc, m_pc);
        checkOutput("out_a", out_a, m_a);
        checkOutput("out_b", out_b, m_b);
        checkOutput("out_imm", out_imm, m_imm);
        checkOutput("out_dest", 16'(out_dest), 16'(m_dest));
        checkOutput("out_wr", 16'(out_wr), 16'(m_wr));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t r;
        logic [2:0] d;

        compared   = 0;
        mismatched = 0;
        modelReset();

        // Directed vectors: {stimulus}, in_ready, rf_addr_2, out_valid, op, a, b, imm, dest, wr
        vecs[0]  = '{'{1'b1, 16'h247F, 16'h0010, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000}, 1'b1, 3'd7, 1'b1, 3'd1, 16'h0000, 16'h0000, 16'hFFFF, 3'd1, 1'b1};
        vecs[1]  = '{'{1'b1, 16'h0881, 16'h0012, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000}, 1'b0, 3'd1, 1'b0, 3'd1, 16'h0000, 16'h0000, 16'hFFFF, 3'd1, 1'b1};
        vecs[2]  = '{'{1'b1, 16'h0881, 16'h0012, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000}, 1'b0, 3'd1, 1'b0, 3'd1, 16'h0000, 16'h0000, 16'hFFFF, 3'd1, 1'b1};
        vecs[3]  = '{'{1'b1, 16'h0881, 16'h0012, 1'b1, 1'b0, 1'b1, 3'd1, 16'h00FF}, 1'b1, 3'd1, 1'b1, 3'd0, 16'h00FF, 16'h00FF, 16'h0000, 3'd2, 1'b1};
        vecs[4]  = '{'{1'b1, 16'h6FFF, 16'h0014, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000}, 1'b1, 3'd7, 1'b1, 3'd3, 16'h0000, 16'h0000, 16'hFFC0, 3'd3, 1'b1};
        vecs[5]  = '{'{1'b1, 16'h8E05, 16'h0016, 1'b1, 1'b0, 1'b1, 3'd3, 16'hABCD}, 1'b1, 3'd3, 1'b1, 3'd4, 16'h4444, 16'hABCD, 16'h0005, 3'd3, 1'b0};
        vecs[6]  = '{'{1'b1, 16'h3601, 16'h0018, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000}, 1'b1, 3'd1, 1'b1, 3'd1, 16'h4444, 16'h0000, 16'h0001, 3'd5, 1'b1};
        vecs[7]  = '{'{1'b1, 16'h5A07, 16'h001A, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000}, 1'b0, 3'd7, 1'b1, 3'd1, 16'h4444, 16'h0000, 16'h0001, 3'd5, 1'b1};
        vecs[8]  = '{'{1'b1, 16'h5A07, 16'h001A, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000}, 1'b0, 3'd7, 1'b1, 3'd1, 16'h4444, 16'h0000, 16'h0001, 3'd5, 1'b1};
        vecs[9]  = '{'{1'b1, 16'h5A07, 16'h001A, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000}, 1'b0, 3'd7, 1'b1, 3'd1, 16'h4444, 16'h0000, 16'h0001, 3'd5, 1'b1};
        vecs[10] = '{'{1'b1, 16'h5A07, 16'h001A, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000}, 1'b0, 3'd7, 1'b0, 3'd1, 16'h4444, 16'h0000, 16'h0001, 3'd5, 1'b1};
        vecs[11] = '{'{1'b1, 16'h1A85, 16'h001C, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000}, 1'b1, 3'd5, 1'b1, 3'd0, 16'h5555, 16'h5555, 16'h0000, 3'd6, 1'b1};
        vecs[12] = '{'{1'b1, 16'h0082, 16'h001E, 1'b1, 1'b0, 1'b1, 3'd2, 16'h1234}, 1'b1, 3'd2, 1'b1, 3'd0, 16'h00FF, 16'h1234, 16'h0000, 3'd0, 1'b0};
        vecs[13] = '{'{1'b1, 16'h0506, 16'h0020, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000}, 1'b0, 3'd6, 1'b0, 3'd0, 16'h00FF, 16'h1234, 16'h0000, 3'd0, 1'b0};
        vecs[14] = '{'{1'b1, 16'h0506, 16'h0020, 1'b1, 1'b0, 1'b1, 3'd6, 16'h0BAD}, 1'b1, 3'd6, 1'b1, 3'd0, 16'h1234, 16'h0BAD, 16'h0000, 3'd1, 1'b1};
        vecs[15] = '{'{1'b0, 16'h0000, 16'h0022, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000}, 1'b1, 3'd0, 1'b0, 3'd0, 16'h1234, 16'h0BAD, 16'h0000, 3'd1, 1'b1};

        // Power-on reset.
        rst_n = 1'b0;
        applyStimulus('0);
        #8;
        checkOutput("reset out_valid", 16'(out_valid), 16'h0000);
        checkOutput("reset out_op", 16'(out_op), 16'h0000);
        checkOutput("reset out_pc", out_pc, 16'h0000);
        checkOutput("reset out_a", out_a, 16'h0000);
        checkOutput("reset out_b", out_b, 16'h0000);
        checkOutput("reset out_imm", out_imm, 16'h0000);
        checkOutput("reset out_dest", 16'(out_dest), 16'h0000);
        checkOutput("reset out_wr", 16'(out_wr), 16'h0000);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed table");
        for (int i = 0; i < 16; i++) begin
            runCycle(vecs[i].s);
            checkOutput($sformatf("vec%0d in_ready", i), 16'(samp_in_ready), 16'(vecs[i].in_ready));
            checkOutput($sformatf("vec%0d rf_addr_2", i), 16'(samp_rf_addr_2), 16'(vecs[i].rf_addr_2));
            checkOutput($sformatf("vec%0d out_valid", i), 16'(out_valid), 16'(vecs[i].out_valid));
            checkOutput($sformatf("vec%0d out_op", i), 16'(out_op), 16'(vecs[i].op));
            checkOutput($sformatf("vec%0d out_a", i), out_a, vecs[i].a);
            checkOutput($sformatf("vec%0d out_b", i), out_b, vecs[i].b);
            checkOutput($sformatf("vec%0d out_imm", i), out_imm, vecs[i].imm);
            checkOutput($sformatf("vec%0d out_dest", i), 16'(out_dest), 16'(vecs[i].dest));
            checkOutput($sformatf("vec%0d out_wr", i), 16'(out_wr), 16'(vecs[i].wr));
        end

        // Reset asserted while an entry is held and registers are pending.
        $display("[TB] reset during stall");
        runCycle('{1'b1, 16'h3007, 16'h0030, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000});
        runCycle('{1'b1, 16'h1484, 16'h0032, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000});
        checkOutput("stall in_ready", 16'(samp_in_ready), 16'h0000);
        checkOutput("stall out_valid", 16'(out_valid), 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async reset out_valid", 16'(out_valid), 16'h0000);
        checkOutput("async reset out_a", out_a, 16'h0000);
        checkOutput("async reset pending cleared", 16'(in_ready), 16'h0001);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runCycle('{1'b1, 16'h1484, 16'h0034, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000});
        checkOutput("post-reset issue out_valid", 16'(out_valid), 16'h0001);
        checkOutput("post-reset issue out_dest", 16'(out_dest), 16'h0005);

        // Randomized traffic against the model.
        $display("[TB] random phase");
        for (int n = 0; n < 1500; n++) begin
            r.in_valid  = ($urandom_range(0, 9) < 7);
            r.instr     = 16'($urandom);
            r.pc        = 16'($urandom);
            r.out_ready = ($urandom_range(0, 9) < 7);
            r.flush     = ($urandom_range(0, 19) == 0);
            r.wb_en     = ($urandom_range(0, 9) < 4);
            r.wb_dest   = 3'($urandom_range(0, 7));
            r.wb_data   = 16'($urandom);
            if (m_pend != 8'h00 && $urandom_range(0, 3) != 0) begin
                r.wb_en = 1'b1;
                for (int t = 0; t < 64; t++) begin
                    d = 3'($urandom_range(1, 7));
                    if (m_pend[d]) begin
                        r.wb_dest = d;
                        break;
                    end
                end
            end
            runCycle(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
